// File: rtl/compact.sv
// compact -- RV32I instruction compressor and halfword packer.
//
// Each accepted 32-bit instruction is rewritten into its 16-bit RVC form when
// compress_en is high and one of the supported rewrite rules matches; otherwise
// it is forwarded unchanged. The resulting stream of 16- and 32-bit codes is
// packed into 32-bit words, lower halfword first. A stream ends with in_last;
// any dangling halfword is then padded with a c.nop (0x0001).
//
// Ports
//   clock        single clock, all state updates on its rising edge
//   reset        asynchronous active-low reset
//   in_valid     input instruction valid
//   in_ready     input accepted when in_valid && in_ready
//   in_instr     uncompressed RV32I instruction
//   in_last      final instruction of a stream, forces a flush
//   compress_en  0: pack only, no compression
//   out_valid    packed word valid (registered)
//   out_ready    sink accepts the word when out_valid && out_ready
//   out_data     packed word, [15:0] holds the earlier halfword
//   out_last     final word of a stream
//   count        number of instructions emitted in 16-bit form (wraps)
module compact #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             in_last,
  input  logic             compress_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_PAD   = 2'd2
  } state_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Returns {match, rvc16}. The first matching rule wins.
  function automatic logic [16:0] f_compress(input logic [31:0] ins);
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic [20:1] imm_j;
    logic [12:1] imm_b;
    logic        rd_c;
    logic        rs1_c;
    logic        rs2_c;
    logic        fit6;
    logic [16:0] r;
    op    = ins[6:0];
    rd    = ins[11:7];
    f3    = ins[14:12];
    rs1   = ins[19:15];
    rs2   = ins[24:20];
    f7    = ins[31:25];
    imm_i = ins[31:20];
    imm_s = {ins[31:25], ins[11:7]};
    imm_j = {ins[31], ins[19:12], ins[20], ins[30:21]};
    imm_b = {ins[31], ins[7], ins[30:25], ins[11:8]};
    // r' registers are x8..x15
    rd_c  = (rd[4:3]  == 2'b01);
    rs1_c = (rs1[4:3] == 2'b01);
    rs2_c = (rs2[4:3] == 2'b01);
    // I-immediate fits a 6-bit signed field
    fit6  = (&imm_i[11:5]) | (~|imm_i[11:5]);
    r     = 17'h0;
    case (op)
      OP_IMM: begin
        case (f3)
          3'b000: begin
            if (ins == 32'h0000_0013)
              r = {1'b1, 16'h0001};
            else if (rd == rs1 && rd != 5'd0 && imm_i != 12'd0 && fit6)
              r = {1'b1, 3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
            else if (rd == 5'd2 && rs1 == 5'd2 && imm_i != 12'd0 && imm_i[3:0] == 4'd0 &&
                     (imm_i[11:9] == 3'b000 || imm_i[11:9] == 3'b111))
              r = {1'b1, 3'b011, imm_i[9], 5'd2, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], 2'b01};
            else if (rs1 == 5'd2 && rd_c && imm_i != 12'd0 && imm_i[1:0] == 2'd0 && imm_i[11:10] == 2'd0)
              r = {1'b1, 3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], 2'b00};
            else if (rs1 == 5'd0 && rd != 5'd0 && fit6)
              r = {1'b1, 3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
            else if (rd != 5'd0 && rs1 != 5'd0 && imm_i == 12'd0)
              r = {1'b1, 4'b1000, rd, rs1, 2'b10};
          end
          3'b001: begin
            if (f7 == 7'd0 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
              r = {1'b1, 3'b000, 1'b0, rd, rs2, 2'b10};
          end
          3'b101: begin
            // ins[30] separates srai from srli
            if ((f7 == 7'b0000000 || f7 == 7'b0100000) && rd == rs1 && rd_c && rs2 != 5'd0)
              r = {1'b1, 3'b100, 1'b0, 1'b0, f7[5], rd[2:0], rs2, 2'b01};
          end
          3'b111: begin
            if (rd == rs1 && rd_c && fit6)
              r = {1'b1, 3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
          end
          default: r = 17'h0;
        endcase
      end
      OP_LUI: begin
        if (rd != 5'd0 && rd != 5'd2 && ins[17:12] != 6'd0 &&
            ((&ins[31:17]) | (~|ins[31:17])))
          r = {1'b1, 3'b011, ins[17], rd, ins[16:12], 2'b01};
      end
      OP_LOAD: begin
        if (f3 == 3'b010) begin
          if (rd_c && rs1_c && imm_i[1:0] == 2'd0 && imm_i[11:7] == 5'd0)
            r = {1'b1, 3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
          else if (rs1 == 5'd2 && rd != 5'd0 && imm_i[1:0] == 2'd0 && imm_i[11:8] == 4'd0)
            r = {1'b1, 3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
        end
      end
      OP_STORE: begin
        if (f3 == 3'b010) begin
          if (rs2_c && rs1_c && imm_s[1:0] == 2'd0 && imm_s[11:7] == 5'd0)
            r = {1'b1, 3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
          else if (rs1 == 5'd2 && rs2 != 5'd0 && imm_s[1:0] == 2'd0 && imm_s[11:8] == 4'd0)
            r = {1'b1, 3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
        end
      end
      OP_JAL: begin
        // offset must fit a 12-bit signed field
        if (((&imm_j[20:11]) | (~|imm_j[20:11])) && (rd == 5'd0 || rd == 5'd1))
          r = {1'b1, (rd == 5'd0) ? 3'b101 : 3'b001, imm_j[11], imm_j[4], imm_j[9:8], imm_j[10],
               imm_j[6], imm_j[7], imm_j[3:1], imm_j[5], 2'b01};
      end
      OP_JALR: begin
        if (f3 == 3'b000 && imm_i == 12'd0 && rs1 != 5'd0 && (rd == 5'd0 || rd == 5'd1))
          r = {1'b1, 3'b100, rd[0], rs1, 5'd0, 2'b10};
      end
      OP_BRANCH: begin
        if ((f3 == 3'b000 || f3 == 3'b001) && rs1_c && rs2 == 5'd0 &&
            ((&imm_b[12:8]) | (~|imm_b[12:8])))
          r = {1'b1, 2'b11, f3[0], imm_b[8], imm_b[4:3], rs1[2:0], imm_b[7:6], imm_b[2:1],
               imm_b[5], 2'b01};
      end
      OP_REG: begin
        if (f3 == 3'b000 && f7 == 7'd0 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
          r = {1'b1, 4'b1001, rd, rs2, 2'b10};
        else if (f3 == 3'b000 && f7 == 7'd0 && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0)
          r = {1'b1, 4'b1000, rd, rs2, 2'b10};
        else if (rd == rs1 && rd_c && rs2_c) begin
          if (f3 == 3'b000 && f7 == 7'b0100000)
            r = {1'b1, 6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
          else if (f3 == 3'b100 && f7 == 7'd0)
            r = {1'b1, 6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
          else if (f3 == 3'b110 && f7 == 7'd0)
            r = {1'b1, 6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
          else if (f3 == 3'b111 && f7 == 7'd0)
            r = {1'b1, 6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
        end
      end
      default: begin
        if (ins == 32'h0010_0073)
          r = {1'b1, 16'h9002};
      end
    endcase
    return r;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_run;
  logic [15:0]      r_p;
  logic             r_out_valid;
  logic [31:0]      r_out_data;
  logic             r_out_last;
  logic [CNT_W-1:0] r_count;

  logic [16:0]      w_cmp;
  logic             w_hit;
  logic [15:0]      w_c;
  logic             w_slot_free;
  logic             w_acc;
  logic             w_load;
  logic [31:0]      w_word;
  logic             w_word_last;
  logic             w_p_we;
  logic [15:0]      w_p_nxt;

  assign w_cmp       = f_compress(in_instr);
  assign w_hit       = compress_en & w_cmp[16];
  assign w_c         = w_cmp[15:0];
  assign w_slot_free = !r_out_valid || out_ready;
  // r_run holds in_ready low during reset and until the first edge after release
  assign in_ready    = r_run && (r_state != ST_PAD) && w_slot_free;
  assign w_acc       = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign count     = r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_acc && w_hit && !in_last) w_state_nxt = ST_HALF;
      ST_HALF: begin
        if (w_acc) begin
          if (w_hit)        w_state_nxt = ST_EMPTY;
          else if (in_last) w_state_nxt = ST_PAD;
        end
      end
      ST_PAD:   if (w_slot_free) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    w_load      = 1'b0;
    w_word      = 32'h0;
    w_word_last = 1'b0;
    w_p_we      = 1'b0;
    w_p_nxt     = r_p;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          if (w_hit && !in_last) begin
            w_p_we  = 1'b1;
            w_p_nxt = w_c;
          end else if (w_hit) begin
            w_load      = 1'b1;
            w_word      = {16'h0001, w_c};
            w_word_last = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_word      = in_instr;
            w_word_last = in_last;
          end
        end
      end
      ST_HALF: begin
        if (w_acc) begin
          w_load = 1'b1;
          if (w_hit) begin
            w_word      = {w_c, r_p};
            w_word_last = in_last;
          end else begin
            // upper half of a 32-bit instruction becomes the new pending halfword
            w_word  = {in_instr[15:0], r_p};
            w_p_we  = 1'b1;
            w_p_nxt = in_instr[31:16];
          end
        end
      end
      ST_PAD: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_word      = {16'h0001, r_p};
          w_word_last = 1'b1;
        end
      end
      default: w_load = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_run       <= 1'b0;
      r_p         <= 16'h0;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'h0;
      r_out_last  <= 1'b0;
      r_count     <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_p_we) r_p <= w_p_nxt;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_word;
        r_out_last  <= w_word_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      if (w_acc && w_hit) r_count <= r_count + CNT_W'(1);
    end
  end

endmodule
